// File: rtl/moore_class_tracker.sv
// moore_class_tracker: tracks one of NUM_CLASSES active classes (or IDLE),
// selected by sel while x is high, with release debounce, minimum dwell
// before exit/switch, a saturating dwell counter and change/invalid pulses.
//
// Optional build macro: MOORE_CLASS_SWITCH_EN enables direct class-to-class
// switching while x=1 (default build: sel ignored while in a class).
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   x            in   request/hold input
//   sel          in   class select, sampled while x=1
//   z            out  state code: 0=IDLE, k+1=class k
//   active       out  high when z!=0
//   changed      out  one-cycle pulse in the first cycle z shows a new value
//   dwell        out  cycles since entry into the current state, saturating
//   invalid_sel  out  one-cycle pulse, IDLE request with out-of-range sel
module moore_class_tracker #(
    parameter int unsigned NUM_CLASSES    = 3,
    parameter int unsigned SEL_W          = 2,
    parameter int unsigned RELEASE_CYCLES = 2,
    parameter int unsigned MIN_DWELL      = 4,
    parameter int unsigned CNT_W          = 8,
    localparam int unsigned Z_W           = $clog2(NUM_CLASSES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic [SEL_W-1:0] sel,
    output logic [Z_W-1:0]   z,
    output logic             active,
    output logic             changed,
    output logic [CNT_W-1:0] dwell,
    output logic             invalid_sel
);

    localparam int unsigned LOW_W = $clog2(RELEASE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLASS = 2'd1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cls_q, cls_d;
    logic [LOW_W-1:0]   low_q, low_d;
    logic [Z_W-1:0]     z_d;
    logic [CNT_W-1:0]   dwell_d;
    logic               changed_d;
    logic               invalid_d;
    logic               sel_ok;
    logic               cls_ok;
    logic               dwell_ok;
    logic               release_ok;

    // Qualifiers shared by the next-state logic.
    always_comb begin
        sel_ok     = {1'b0, sel}   < (SEL_W+1)'(NUM_CLASSES);
        cls_ok     = {1'b0, cls_q} < (SEL_W+1)'(NUM_CLASSES);
        dwell_ok   = 32'(dwell) >= MIN_DWELL;
        release_ok = (32'(low_q) + 32'd1) >= RELEASE_CYCLES;
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        low_d     = low_q;
        invalid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                low_d = '0;
                if (x) begin
                    if (sel_ok) begin
                        state_d = S_CLASS;
                        cls_d   = sel;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
            end
            S_CLASS: begin
                if (!cls_ok) begin
                    state_d = S_IDLE;
                    cls_d   = '0;
                    low_d   = '0;
                end else if (x) begin
                    low_d = '0;
`ifdef MOORE_CLASS_SWITCH_EN
                    if (sel_ok && (sel != cls_q) && dwell_ok) begin
                        cls_d = sel;
                    end
`endif
                end else if (release_ok && dwell_ok) begin
                    state_d = S_IDLE;
                    cls_d   = '0;
                    low_d   = '0;
                end else if (release_ok) begin
                    low_d = LOW_W'(RELEASE_CYCLES);
                end else begin
                    low_d = low_q + LOW_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cls_d   = '0;
                low_d   = '0;
            end
        endcase

        z_d = (state_d == S_CLASS) ? (Z_W'(cls_d) + Z_W'(1)) : '0;

        // Any visible state change restarts dwell and the release count.
        changed_d = (z_d != z);
        if (changed_d) begin
            dwell_d = '0;
            low_d   = '0;
        end else if (dwell == {CNT_W{1'b1}}) begin
            dwell_d = dwell;
        end else begin
            dwell_d = dwell + CNT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cls_q       <= '0;
            low_q       <= '0;
            z           <= '0;
            active      <= 1'b0;
            changed     <= 1'b0;
            dwell       <= '0;
            invalid_sel <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            low_q       <= low_d;
            z           <= z_d;
            active      <= (z_d != '0);
            changed     <= changed_d;
            dwell       <= dwell_d;
            invalid_sel <= invalid_d;
        end
    end

endmodule
